uart_tx_fifo: RTL and testbench

UART_TX_FIFO -- requirements
Module: uart_tx_fifo

---
 rtl/uart_tx_fifo.sv | 239 +++++++++++++++++++++++
 tb/tb_uart_tx_fifo.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: UART transmitter fed by a small transmit queue.
// Frames are start(0), DATA_BITS data LSB first, optional parity, STOP_BITS stop(1).
// Parity support (PARITY state, PARITY_ODD parameter) is compiled only when the
// macro UART_TX_PARITY_EN is defined; otherwise DATA goes straight to STOP.
//
// state  | meaning
// IDLE   | line high, waiting for a queued word
// START  | start bit (0) on the line
// DATA   | payload bits, LSB first
// PARITY | parity bit (only with UART_TX_PARITY_EN)
// STOP   | stop bit(s) (1); pops the next word here for gapless frames
module uart_tx_fifo #(
    parameter int DATA_BITS  = 8,
    parameter int BAUD_DIV   = 5208,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 4
`ifdef UART_TX_PARITY_EN
    ,
    parameter int PARITY_ODD = 0
`endif
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 trmt,
    input  logic [DATA_BITS-1:0] tx_data,
    output logic                 TX,
    output logic                 tx_done,
    output logic                 full,
    output logic                 empty,
    output logic                 ovf
);

    localparam int AW     = $clog2(FIFO_DEPTH);
    localparam int PW     = AW + 1;
    localparam int BAUD_W = $clog2(BAUD_DIV);
    localparam int BIT_W  = 4;

    localparam logic [BAUD_W-1:0] BAUD_LOAD = BAUD_W'(BAUD_DIV - 1);
    localparam logic [BIT_W-1:0]  LAST_DATA = BIT_W'(DATA_BITS - 1);
    localparam logic [BIT_W-1:0]  LAST_STOP = BIT_W'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_TX_PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;

    state_t                state_q, state_nxt;
    logic                  tx_q, tx_nxt;
    logic [BAUD_W-1:0]     baud_cnt, baud_nxt;
    logic [BIT_W-1:0]      bit_cnt, bit_nxt;
    logic [DATA_BITS-1:0]  shift_q, shift_nxt;
    logic                  done_q;
    logic                  ovf_q;
    logic                  pop;
    logic                  done_set;
    logic                  push_ok;
`ifdef UART_TX_PARITY_EN
    logic                  par_q, par_nxt;
`endif

    logic [DATA_BITS-1:0]  mem [FIFO_DEPTH];
    logic [PW-1:0]         wr_ptr, rd_ptr;
    logic [DATA_BITS-1:0]  rd_data;
    logic                  full_w, empty_w;

    // The extra pointer bit separates a wrapped (full) queue from an empty one.
    assign full_w  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty_w = (wr_ptr == rd_ptr);
    assign rd_data = mem[rd_ptr[AW-1:0]];
    // A push while full is dropped even if a pop frees a slot on the same edge.
    assign push_ok = trmt && !full_w;

    assign TX      = tx_q;
    assign tx_done = done_q;
    assign full    = full_w;
    assign empty   = empty_w;
    assign ovf     = ovf_q;

    // Queue storage: written on accepted pushes only, no reset needed.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr[AW-1:0]] <= tx_data;
        end
    end

    // Queue pointers and the sticky overflow flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            ovf_q  <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            if (trmt && full_w) begin
                ovf_q <= 1'b1;
            end
        end
    end

    // FSM state, line register, counters and the frame shifter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            tx_q     <= 1'b1;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            shift_q  <= '0;
`ifdef UART_TX_PARITY_EN
            par_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_nxt;
            tx_q     <= tx_nxt;
            baud_cnt <= baud_nxt;
            bit_cnt  <= bit_nxt;
            shift_q  <= shift_nxt;
`ifdef UART_TX_PARITY_EN
            par_q    <= par_nxt;
`endif
        end
    end

    // tx_done: an accepted push wins over the end-of-frame set on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done_q <= 1'b0;
        end else if (push_ok) begin
            done_q <= 1'b0;
        end else if (done_set) begin
            done_q <= 1'b1;
        end
    end

    // Next-state, next line level and counter updates at each bit boundary.
    always_comb begin
        state_nxt = state_q;
        tx_nxt    = tx_q;
        baud_nxt  = baud_cnt;
        bit_nxt   = bit_cnt;
        shift_nxt = shift_q;
        pop       = 1'b0;
        done_set  = 1'b0;
`ifdef UART_TX_PARITY_EN
        par_nxt   = par_q;
`endif
        case (state_q)
            IDLE: begin
                tx_nxt   = 1'b1;
                baud_nxt = '0;
                bit_nxt  = '0;
                if (!empty_w) begin
                    pop       = 1'b1;
                    state_nxt = START;
                    tx_nxt    = 1'b0;
                    baud_nxt  = BAUD_LOAD;
                end
            end
            default: begin
                if (baud_cnt != '0) begin
                    baud_nxt = baud_cnt - BAUD_W'(1);
                end else begin
                    baud_nxt = BAUD_LOAD;
                    case (state_q)
                        START: begin
                            state_nxt = DATA;
                            tx_nxt    = shift_q[0];
                            shift_nxt = shift_q >> 1;
                            bit_nxt   = '0;
                        end
                        DATA: begin
                            if (bit_cnt == LAST_DATA) begin
                                bit_nxt = '0;
`ifdef UART_TX_PARITY_EN
                                state_nxt = PARITY;
                                tx_nxt    = par_q;
`else
                                state_nxt = STOP;
                                tx_nxt    = 1'b1;
`endif
                            end else begin
                                bit_nxt   = bit_cnt + BIT_W'(1);
                                tx_nxt    = shift_q[0];
                                shift_nxt = shift_q >> 1;
                            end
                        end
`ifdef UART_TX_PARITY_EN
                        PARITY: begin
                            state_nxt = STOP;
                            tx_nxt    = 1'b1;
                            bit_nxt   = '0;
                        end
`endif
                        STOP: begin
                            if (bit_cnt == LAST_STOP) begin
                                bit_nxt = '0;
                                if (!empty_w) begin
                                    pop       = 1'b1;
                                    state_nxt = START;
                                    tx_nxt    = 1'b0;
                                end else begin
                                    state_nxt = IDLE;
                                    tx_nxt    = 1'b1;
                                    baud_nxt  = '0;
                                    done_set  = 1'b1;
                                end
                            end else begin
                                bit_nxt = bit_cnt + BIT_W'(1);
                            end
                        end
                        default: begin
                            state_nxt = IDLE;
                            tx_nxt    = 1'b1;
                            baud_nxt  = '0;
                            bit_nxt   = '0;
                        end
                    endcase
                end
            end
        endcase
        // The popped word is latched into the shifter as its start bit begins.
        if (pop) begin
            shift_nxt = rd_data;
`ifdef UART_TX_PARITY_EN
            par_nxt   = (^rd_data) ^ (PARITY_ODD != 0);
`endif
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: two transmitters (1 and 2 stop bits, BAUD_DIV=16, depth 4)
// compared each cycle against a frame-level reference model, plus directed
// checks of frame shape, latency, overflow, back-to-back and reset behaviour.
module tb_uart_tx_fifo;

    localparam int BAUD  = 16;
    localparam int DEPTH = 4;
`ifdef UART_TX_PARITY_EN
    localparam int PBITS      = 1;
    localparam int TB_PAR_ODD = 0;
`else
    localparam int PBITS      = 0;
`endif
    localparam int FLEN0 = 10 + PBITS;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       trmt_v [2];
    logic [7:0] data_v [2];
    logic       tx_w [2];
    logic       done_w [2];
    logic       full_w [2];
    logic       empty_w [2];
    logic       ovf_w [2];

    int n_cmp = 0;
    int n_bad = 0;

    // reference model state, per transmitter
    logic [7:0]  mq [2][DEPTH];
    int          mcnt [2];
    logic [15:0] mframe [2];
    int          mlen [2];
    int          mpos [2];
    bit          mact [2];
    logic        mdone [2];
    logic        movf [2];
    logic        mtx [2];

    always #5 clk = ~clk;

    uart_tx_fifo #(.DATA_BITS(8), .BAUD_DIV(BAUD), .STOP_BITS(1), .FIFO_DEPTH(DEPTH)
`ifdef UART_TX_PARITY_EN
        , .PARITY_ODD(TB_PAR_ODD)
`endif
    ) dut0 (
        .clk(clk), .rst_n(rst_n), .trmt(trmt_v[0]), .tx_data(data_v[0]),
        .TX(tx_w[0]), .tx_done(done_w[0]), .full(full_w[0]), .empty(empty_w[0]), .ovf(ovf_w[0])
    );

    uart_tx_fifo #(.DATA_BITS(8), .BAUD_DIV(BAUD), .STOP_BITS(2), .FIFO_DEPTH(DEPTH)
`ifdef UART_TX_PARITY_EN
        , .PARITY_ODD(TB_PAR_ODD)
`endif
    ) dut1 (
        .clk(clk), .rst_n(rst_n), .trmt(trmt_v[1]), .tx_data(data_v[1]),
        .TX(tx_w[1]), .tx_done(done_w[1]), .full(full_w[1]), .empty(empty_w[1]), .ovf(ovf_w[1])
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int stop_of(input int i);
        return (i == 0) ? 1 : 2;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            mcnt[i] = 0; mact[i] = 0; mpos[i] = 0; mlen[i] = 0;
            mdone[i] = 1'b0; movf[i] = 1'b0; mtx[i] = 1'b1; mframe[i] = '0;
        end
    endtask

    // One clock edge of the reference: line advances one clock, a finished
    // frame is replaced by the next queued word, then the push is applied.
    task automatic model_step(input int i, input logic t, input logic [7:0] d);
        int   n;
        int   idx;
        bit   was;
        bit   dset;
        bit   acc;
        logic [7:0] b;
        n = mcnt[i];
        was = mact[i];
        dset = 0;
        if (mact[i]) begin
            mpos[i]++;
            if (mpos[i] == mlen[i] * BAUD) mact[i] = 0;
        end
        if (!mact[i]) begin
            if (n > 0) begin
                b = mq[i][0];
                for (int k = 0; k < DEPTH - 1; k++) mq[i][k] = mq[i][k+1];
                mcnt[i]--;
                mframe[i] = '0;
                for (int k = 0; k < 8; k++) mframe[i][1+k] = b[k];
                idx = 9;
`ifdef UART_TX_PARITY_EN
                mframe[i][9] = (^b) ^ (TB_PAR_ODD != 0);
                idx = 10;
`endif
                for (int s = 0; s < stop_of(i); s++) mframe[i][idx+s] = 1'b1;
                mlen[i] = idx + stop_of(i);
                mpos[i] = 0;
                mact[i] = 1;
            end else if (was) begin
                dset = 1;
            end
        end
        mtx[i] = mact[i] ? mframe[i][mpos[i] / BAUD] : 1'b1;
        acc = t && (n < DEPTH);
        if (t && !acc) movf[i] = 1'b1;
        if (acc) begin
            mq[i][mcnt[i]] = d;
            mcnt[i]++;
            mdone[i] = 1'b0;
        end else if (dset) begin
            mdone[i] = 1'b1;
        end
    endtask

    task automatic check_all();
        for (int i = 0; i < 2; i++) begin
            check($sformatf("tx%0d", i),    32'(tx_w[i]),    32'(mtx[i]));
            check($sformatf("done%0d", i),  32'(done_w[i]),  32'(mdone[i]));
            check($sformatf("full%0d", i),  32'(full_w[i]),  32'(mcnt[i] == DEPTH));
            check($sformatf("empty%0d", i), 32'(empty_w[i]), 32'(mcnt[i] == 0));
            check($sformatf("ovf%0d", i),   32'(ovf_w[i]),   32'(movf[i]));
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step(0, trmt_v[0], data_v[0]);
        model_step(1, trmt_v[1], data_v[1]);
        @(negedge clk);
        check_all();
    endtask

    task automatic cyc(input logic t0, input logic [7:0] d0, input logic t1, input logic [7:0] d1);
        trmt_v[0] = t0; data_v[0] = d0;
        trmt_v[1] = t1; data_v[1] = d1;
        tick();
        trmt_v[0] = 1'b0;
        trmt_v[1] = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int         st;
        int         dn;
        int         run1;
        int         m;
        int         lim;
        bit         f1;
        logic [10:0] samp;
        logic [10:0] seq;
        int         p;

        trmt_v[0] = 1'b0; trmt_v[1] = 1'b0;
        data_v[0] = '0;   data_v[1] = '0;
        model_reset();
        repeat (3) @(negedge clk);
        check("rst_tx",    32'(tx_w[0]),    32'd1);
        check("rst_empty", 32'(empty_w[1]), 32'd1);
        check("rst_done",  32'(done_w[0]),  32'd0);
        rst_n = 1'b1;

        // 0xA5 on the 1-stop unit, 0x00 on the 2-stop unit
        samp = '0;
`ifdef UART_TX_PARITY_EN
        seq = {1'b1, 1'(TB_PAR_ODD != 0), 8'hA5, 1'b0};
`else
        seq = {1'b0, 1'b1, 8'hA5, 1'b0};
`endif
        cyc(1'b1, 8'hA5, 1'b1, 8'h00);
        st = -1; dn = -1; run1 = 0; f1 = 0;
        for (int k = 1; k < 450; k++) begin
            cyc(1'b0, 8'h00, 1'b0, 8'h00);
            if (st < 0 && tx_w[0] == 1'b0) st = k;
            if (dn < 0 && done_w[0]) dn = k;
            if (st >= 0 && k >= st + 8 && ((k - st - 8) % BAUD) == 0 && ((k - st - 8) / BAUD) < FLEN0)
                samp[(k - st - 8) / BAUD] = tx_w[0];
            if (done_w[1] && !f1) begin
                check("stop2_high", 32'(run1), 32'd32);
                f1 = 1;
            end
            run1 = tx_w[1] ? run1 + 1 : 0;
            if (dn >= 0 && f1) break;
        end
        check("start_latency", 32'(st), 32'd1);
        check("a5_done_lat", 32'(dn - st), 32'(FLEN0 * BAUD));
        check("a5_bits", 32'(samp), 32'(seq));
        check("stop2_done_seen", 32'(f1), 32'd1);

        // push with tx_done set clears it on the next edge
        cyc(1'b0, 8'h00, 1'b1, 8'h81);
        check("done_clr", 32'(done_w[1]), 32'd0);

        // push during the last stop bit: next start bit follows with no gap
        lim = 0;
        while (!(mact[1] && mpos[1] >= (mlen[1] - 1) * BAUD + 2) && lim < 400) begin
            cyc(1'b0, 8'h00, 1'b0, 8'h00);
            lim++;
        end
        check("stop_reach", 32'(lim < 400), 32'd1);
        cyc(1'b0, 8'h00, 1'b1, 8'h7E);
        m = mpos[1];
        for (int k = 0; k < mlen[1] * BAUD - m - 1; k++) cyc(1'b0, 8'h00, 1'b0, 8'h00);
        check("b2b_last_stop", 32'(tx_w[1]), 32'd1);
        cyc(1'b0, 8'h00, 1'b0, 8'h00);
        check("b2b_start", 32'(tx_w[1]), 32'd0);

        // overflow burst while busy
        cyc(1'b1, 8'h11, 1'b0, 8'h00);
        repeat (20) cyc(1'b0, 8'h00, 1'b0, 8'h00);
        for (int b = 1; b <= 5; b++) begin
            cyc(1'b1, 8'(b), 1'b0, 8'h00);
            if (b == 4) check("burst_full4", 32'(full_w[0]), 32'd1);
            if (b == 4) check("burst_ovf4", 32'(ovf_w[0]), 32'd0);
            if (b == 5) check("burst_ovf5", 32'(ovf_w[0]), 32'd1);
        end
        lim = 0;
        while (!(mcnt[0] == 0 && !mact[0] && mcnt[1] == 0 && !mact[1]) && lim < 1500) begin
            cyc(1'b0, 8'h00, 1'b0, 8'h00);
            lim++;
        end
        cyc(1'b0, 8'h00, 1'b0, 8'h00);
        check("drain_done0", 32'(done_w[0]), 32'd1);

        // asynchronous reset in the middle of DATA
        cyc(1'b1, 8'h3C, 1'b0, 8'h00);
        lim = 0;
        while (!(mact[0] && mpos[0] == 20) && lim < 100) begin
            cyc(1'b0, 8'h00, 1'b0, 8'h00);
            lim++;
        end
        check("mid_data_low", 32'(tx_w[0]), 32'd0);
        #2 rst_n = 1'b0;
        #1;
        check("arst_tx",    32'(tx_w[0]),    32'd1);
        check("arst_empty", 32'(empty_w[0]), 32'd1);
        check("arst_done",  32'(done_w[0]),  32'd0);
        check("arst_ovf",   32'(ovf_w[0]),   32'd0);
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        check_all();
        cyc(1'b1, 8'h5A, 1'b0, 8'h00);
        repeat (200) cyc(1'b0, 8'h00, 1'b0, 8'h00);
        check("post_rst_done", 32'(done_w[0]), 32'd1);

        // random traffic at light, medium and heavy push rates
        for (int ph = 0; ph < 3; ph++) begin
            p = (ph == 0) ? 2 : (ph == 1) ? 6 : 40;
            repeat (2500) begin
                cyc(1'($urandom_range(0, 99) < p), 8'($urandom),
                    1'($urandom_range(0, 99) < p), 8'($urandom));
            end
        end
        lim = 0;
        while (!(mcnt[0] == 0 && !mact[0] && mcnt[1] == 0 && !mact[1]) && lim < 1500) begin
            cyc(1'b0, 8'h00, 1'b0, 8'h00);
            lim++;
        end
        check("final_drain", 32'(lim < 1500), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
